// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: INCR bursts, full-width beats, one outstanding
// transaction per direction; write and read paths run independently.
//
// Ports:
//   ACLK, ARESETn          clock, synchronous active-low reset
//   AW*: AWADDR AWLEN AWVALID AWREADY      write address channel
//   W*:  WDATA WSTRB WLAST WVALID WREADY   write data channel
//   B*:  BRESP BVALID BREADY               write response channel
//   AR*: ARADDR ARLEN ARVALID ARREADY      read address channel
//   R*:  RDATA RRESP RLAST RVALID RREADY   read data channel
module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BSH    = $clog2(STRB_W);
  // One spare bit so idx+1 never wraps back into range.
  localparam int IDX_W  = ADDR_WIDTH - BSH + 1;
  localparam int MW     = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(MEM_DEPTH);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FIRST,
    R_DATA
  } rstate_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Write path state
  wstate_t          r_wstate;
  logic             r_awready;
  logic             r_wready;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic [IDX_W-1:0] r_widx;
  logic [7:0]       r_wlen;
  logic [7:0]       r_wcnt;
  logic             r_werr;

  // Read path state
  rstate_t          r_rstate;
  logic             r_arready;
  logic             r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]       r_rresp;
  logic             r_rlast;
  logic [IDX_W-1:0] r_ridx;
  logic [7:0]       r_rlen;
  logic [7:0]       r_rcnt;

  logic             w_w_fire;
  logic             w_w_last;
  logic             w_w_oob;
  logic             w_w_berr;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_aw_idx;
  logic [IDX_W-1:0] w_ar_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_oob;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [7:0]       w_rcnt_nxt;
  logic             w_unused_ok;

  // Sub-word address bits carry no meaning for full-width beats.
  assign w_unused_ok = ^{AWADDR[BSH-1:0], ARADDR[BSH-1:0]};

  assign w_aw_idx = {1'b0, AWADDR[ADDR_WIDTH-1:BSH]};
  assign w_ar_idx = {1'b0, ARADDR[ADDR_WIDTH-1:BSH]};

  assign w_w_fire = (r_wstate == W_DATA) && WVALID && r_wready;
  assign w_w_last = (r_wcnt == r_wlen);
  assign w_w_oob  = (r_widx >= DEPTH_I);
  // WLAST must be high exactly on the final counted beat.
  assign w_w_berr = w_w_oob || (WLAST != w_w_last);
  assign w_mem_we = w_w_fire && !w_w_oob && ARESETn;

  // R_FIRST loads the latched index; streaming loads the next one.
  assign w_rd_idx = (r_rstate == R_FIRST) ? r_ridx
                                          : r_ridx + IDX_W'(1);
  assign w_rd_oob = (w_rd_idx >= DEPTH_I);
  assign w_rd_word = w_rd_oob ? '0 : r_mem[w_rd_idx[MW-1:0]];
  assign w_rcnt_nxt = r_rcnt + 8'd1;

  // Memory array: byte-enabled write, no reset.
  always_ff @(posedge ACLK) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) begin
          r_mem[r_widx[MW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
        end
      end
    end
  end

  // Write FSM
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (AWVALID && r_awready) begin
            r_widx    <= w_aw_idx;
            r_wlen    <= AWLEN;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_fire) begin
            if (w_w_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr || w_w_berr) ? SLVERR : OKAY;
              r_wstate <= W_RESP;
            end else begin
              r_widx <= r_widx + IDX_W'(1);
              r_wcnt <= r_wcnt + 8'd1;
              r_werr <= r_werr | w_w_berr;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
      r_rlast   <= 1'b0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (ARVALID && r_arready) begin
            r_ridx    <= w_ar_idx;
            r_rlen    <= ARLEN;
            r_rcnt    <= '0;
            r_arready <= 1'b0;
            r_rstate  <= R_FIRST;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_FIRST: begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_rd_word;
          r_rresp  <= w_rd_oob ? SLVERR : OKAY;
          r_rlast  <= (r_rlen == 8'd0);
          r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (RREADY) begin
            if (r_rcnt == r_rlen) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_ridx  <= w_rd_idx;
              r_rcnt  <= w_rcnt_nxt;
              r_rdata <= w_rd_word;
              r_rresp <= w_rd_oob ? SLVERR : OKAY;
              r_rlast <= (w_rcnt_nxt == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign RLAST   = r_rlast;

endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
AXI4 slave memory that terminates the write (AW/W/B) and read (AR/R) channels of the AXI4 interface. It produces the BRESP/RRESP traffic that the bus checker monitors. INCR bursts only, full-width beats, one outstanding transaction per direction. The write and read paths run concurrently and independently.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 32, data bus width; word index = addr >> log2(DATA_WIDTH/8)
MEM_DEPTH, 1024, number of DATA_WIDTH words in the array

Ports:
ACLK  in  1  clock; all logic on posedge
ARESETn  in  1  reset, synchronous, active-low
AWADDR  in  ADDR_WIDTH  write burst start byte address
AWLEN  in  8  beats minus one
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables
WLAST  in  1  last write beat
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read burst start byte address
ARLEN  in  8  beats minus one
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RLAST  out  1  last read beat
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset (ARESETn=0 at a posedge): all outputs 0, both FSMs to IDLE, beat counters 0, error flags cleared. Memory contents are not reset. AWREADY/ARREADY go to 1 on the first posedge with ARESETn=1.
- Handshake: a transfer occurs on a posedge where VALID && READY. Once BVALID/RVALID is asserted, it stays asserted and BRESP/RDATA/RRESP/RLAST stay stable until the handshake.
- Write FSM:
  - W_IDLE (AWREADY=1). On the AW handshake: latch the word index and AWLEN, clear the beat count and error flag, set AWREADY=0, go to W_DATA.
  - W_DATA (WREADY=1). On each W handshake, write the bytes enabled by WSTRB to mem[idx], then idx+1 and count+1.
  - On the beat where count==len: set WREADY=0, BVALID=1, go to W_RESP. The burst ends on this count regardless of WLAST.
  - W_RESP: on the B handshake, set BVALID=0, AWREADY=1, go to W_IDLE.
- Write errors: set BRESP=2'b10 (SLVERR) if any beat idx>=MEM_DEPTH (that beat's write is dropped), or if WLAST is asserted on a beat other than count==len, or is 0 on that beat. Otherwise BRESP=2'b00.
- Read FSM:
  - R_IDLE (ARREADY=1). On the AR handshake: latch idx and len, set ARREADY=0, go to R_DATA.
  - First beat: RVALID=1 on the posedge after the AR handshake (1-cycle latency), with RDATA=mem[idx] registered.
  - Each R handshake with count<len: load the next beat on the same edge, keeping RVALID=1. This gives zero-bubble streaming.
  - RLAST=1 only on beat count==len.
  - After the last handshake: RVALID=0, RLAST=0, ARREADY=1, go to R_IDLE.
- Read errors: a beat with idx>=MEM_DEPTH returns RDATA=0 with RRESP=2'b10. Other beats return RRESP=2'b00.
- BRESP and RRESP hold their last value after the handshake until the next response is loaded. The monitor samples them on the cycle after the handshake.
- Same-cycle read and write to the same word: the read returns the pre-write data.
- Index wrap: idx is not wrapped modulo MEM_DEPTH. Out-of-range beats follow the error rules above.
- Reset mid-burst: the burst is abandoned, beats already written remain in memory, and no B or R response is issued for it.

Test Plan:
1. AWADDR=0x0010, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=0xF -> BVALID, BRESP=00. Then ARADDR=0x0010, ARLEN=0 -> RVALID one cycle after AR handshake, RDATA=0xDEADBEEF, RLAST=1, RRESP=00.
2. 4-beat write at 0x0100 with 0x11111111..0x44444444. Then single write to 0x0108, WDATA=0xFFFFFFFF, WSTRB=0x3. Then 4-beat read -> 0x11111111, 0x22222222, 0x3333FFFF, 0x44444444; RLAST only on beat 4; RRESP=00 throughout.
3. Backpressure:
   - RREADY=0 for 3 cycles during beat 2 -> RVALID, RDATA, RLAST stable across all 3 cycles.
   - BREADY=0 for 5 cycles -> BVALID held and AWREADY=0 throughout.
4. AWADDR=0x0FFC, AWLEN=1, data 0xA5A5A5A5/0x5A5A5A5A -> word 1023=0xA5A5A5A5, beat 2 dropped, BRESP=10. Read the same burst -> beat 1 RRESP=00 with 0xA5A5A5A5; beat 2 RRESP=10 with RDATA=0.
5. AWLEN=3 with WLAST=1 on beat 2 -> WREADY stays 1 until 4 beats are accepted; BRESP=10.
6. ARESETn=0 for 1 cycle during beat 2 of an 8-beat read -> RVALID=0 and ARREADY=0 on the next edge, ARREADY=1 on the following edge. A new read then returns correct data with RRESP=00.
